// File: rtl/ram_latency_ctrl.sv
// ram_latency_ctrl
//
// Word-addressed main-memory model with a programmable access latency. It
// serves the single RAM request port of the coherence/arbitration controller
// and reports progress on ramstate, which the controller uses to release
// iwait/dwait.
//
// Parameters:
//   LAT        wait cycles before ACCESS (1..15)
//   ADDR_BITS  log2 of memory depth in 32-bit words (DEPTH = 2**ADDR_BITS)
//
// Ports:
//   CLK       in   1   clock, rising edge
//   RST       in   1   synchronous active-high reset
//   ramREN    in   1   read request
//   ramWEN    in   1   write request
//   ramaddr   in  32   byte address, word index = ramaddr[ADDR_BITS+1:2]
//   ramstore  in  32   write data
//   ramload   out 32   read data, non-zero only in a read ACCESS cycle
//   ramstate  out  2   FREE=00, BUSY=01, ACCESS=10, ERROR=11
//
// Build option:
//   RAM_ADDR_CHECK_EN  when defined, a request with a misaligned address or
//                      with address bits above the memory set is rejected with
//                      ERROR. When undefined those bits are ignored and
//                      addresses alias modulo DEPTH words.

module ram_latency_ctrl #(
  parameter int LAT       = 4,
  parameter int ADDR_BITS = 10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] ACC  = 2'd2;

  localparam logic [1:0] FREE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] ACCESS = 2'b10;
  localparam logic [1:0] ERROR  = 2'b11;

  // IDLE consumes one of the LAT busy cycles and WAIT exits on cnt==0,
  // so WAIT is loaded with LAT-2.
  localparam logic [3:0] CNT_INIT = (LAT > 1) ? 4'(LAT - 2) : 4'd0;

  logic [31:0] mem [DEPTH];

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [31:0] laddr;
  logic        lren;
  logic        lwen;
  logic [31:0] lstore;

  logic        addr_bad;
  logic        req_any;
  logic        req_err;
  logic        req_valid;
  logic        req_match;
  logic [ADDR_BITS-1:0] lidx;

  assign lidx = laddr[ADDR_BITS+1:2];

`ifdef RAM_ADDR_CHECK_EN
  // Any bit outside the word index (byte offset or above the memory) is illegal.
  localparam logic [31:0] IDX_MASK = ((32'd1 << (ADDR_BITS + 2)) - 32'd1) & ~32'd3;
  assign addr_bad = |(ramaddr & ~IDX_MASK);
`else
  assign addr_bad = 1'b0;
`endif

  assign req_any   = ramREN | ramWEN;
  assign req_err   = (ramREN & ramWEN) | (req_any & addr_bad);
  assign req_valid = req_any & ~req_err;

  // Store data only matters for writes; a read keeps its identity while the
  // write-data bus wanders.
  assign req_match = (lren == ramREN) && (lwen == ramWEN) && (laddr == ramaddr) &&
                     (!ramWEN || (lstore == ramstore));

  always_comb begin
    ramstate = BUSY;
    if (!req_any) begin
      ramstate = FREE;
    end else if (req_err) begin
      ramstate = ERROR;
    end else if (state == ACC && req_match) begin
      ramstate = ACCESS;
    end
  end

  always_comb begin
    ramload = 32'd0;
    if (state == ACC && req_match && lren && !req_err) begin
      ramload = mem[lidx];
    end
  end

  // Any cycle without a valid request (idle, error or illegal address) sends
  // the FSM home; a changed request in WAIT also aborts so it restarts from
  // IDLE and is latched fresh. ACC always lasts exactly one cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      laddr  <= 32'd0;
      lren   <= 1'b0;
      lwen   <= 1'b0;
      lstore <= 32'd0;
    end else if (!req_valid) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          laddr  <= ramaddr;
          lren   <= ramREN;
          lwen   <= ramWEN;
          lstore <= ramstore;
          if (LAT == 1) begin
            state <= ACC;
          end else begin
            state <= WAIT;
            cnt   <= CNT_INIT;
          end
        end
        WAIT: begin
          if (!req_match) begin
            state <= IDLE;
          end else if (cnt == 4'd0) begin
            state <= ACC;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The array has no reset so it can map onto block RAM; a write commits only
  // on the edge that closes a matching ACCESS cycle and is dropped by RST.
  always_ff @(posedge CLK) begin
    if (!RST && state == ACC && req_match && lwen && req_valid) begin
      mem[lidx] <= lstore;
    end
  end

endmodule
